lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 29 ++
 rtl/lsu.sv | 83 ++++++++
 2 files changed

// File: rtl/lsu_if.sv
// lsu_if: execute-stage request, memory bus and completion signals of the LSU
//   slave  : LSU side (takes requests and read data, drives the bus and completion)
//   master : environment side (execute stage plus memory)
interface lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  lsu_op_i;
  logic [31:0] addr_i;
  logic [31:0] st_data_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        done_o;
  logic [31:0] ld_data_o;
  logic        err_o;
  modport slave (
    input  req_valid_i, lsu_op_i, addr_i, st_data_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, done_o, ld_data_o, err_o
  );
  modport master (
    output req_valid_i, lsu_op_i, addr_i, st_data_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, done_o, ld_data_o, err_o
  );
endinterface

// File: rtl/lsu.sv
// lsu: RV32 load/store unit with a req/gnt/rvalid memory port and byte/half/word access
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : request handshake, memory bus, done/err pulses and extended load data
module lsu (
  input logic clk_i,
  input logic rst_i,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state_q;
  logic [3:0]  op_q, be_q, be_d;
  logic [1:0]  off_q, sz;
  logic [31:0] addr_q, wdata_q, wdata_d, ld_q, ld_d;
  logic        req_q, we_q, done_q, err_q, legal, misal, fire;
  logic [7:0]  b_sel;
  logic [15:0] h_sel;
  assign sz      = bus.lsu_op_i[1:0];
  assign legal   = bus.lsu_op_i inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
  assign misal   = (sz == 2'd1 && bus.addr_i[0]) || (sz == 2'd2 && bus.addr_i[1:0] != 2'd0);
  assign fire    = bus.req_valid_i && state_q == IDLE;
  assign be_d    = sz == 2'd0 ? 4'b0001 << bus.addr_i[1:0] :
                   sz == 2'd1 ? 4'b0011 << {bus.addr_i[1], 1'b0} : 4'b1111;
  assign wdata_d = sz == 2'd0 ? {4{bus.st_data_i[7:0]}} :
                   sz == 2'd1 ? {2{bus.st_data_i[15:0]}} : bus.st_data_i;
  assign b_sel   = 8'(bus.mem_rdata_i >> {off_q, 3'b000});
  assign h_sel   = 16'(bus.mem_rdata_i >> {off_q[1], 4'b0000});
  // funct3[2] marks the unsigned variants, so it suppresses sign extension
  assign ld_d    = op_q[1] ? bus.mem_rdata_i :
                   op_q[0] ? {{16{~op_q[2] & h_sel[15]}}, h_sel} : {{24{~op_q[2] & b_sel[7]}}, b_sel};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      ld_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (fire) begin
          if (!legal || misal) err_q <= 1'b1;
          else begin
            state_q <= REQ;
            req_q   <= 1'b1;
            op_q    <= bus.lsu_op_i;
            off_q   <= bus.addr_i[1:0];
            addr_q  <= {bus.addr_i[31:2], 2'b00};
            we_q    <= bus.lsu_op_i[3];
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end
        end
        REQ: if (bus.mem_gnt_i) begin
          req_q   <= 1'b0;
          state_q <= op_q[3] ? IDLE : WAIT;
          done_q  <= op_q[3];
        end
        WAIT: if (bus.mem_rvalid_i) begin
          state_q <= IDLE;
          ld_q    <= ld_d;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.req_ready_o = state_q == IDLE;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_be_o    = be_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.ld_data_o   = ld_q;
endmodule
